// File: rtl/datapath_filtro.sv
// Biquad IIR arithmetic stage: coefficient bank, delay line, MAC accumulator.
// Ports: clk/reset, muestra_*, coef_*, paso/Sel_cons/Sel_ac/listo in; salida/salida_valid/busy/overrun out.
module datapath_filtro #(
  parameter int W    = 16,
  parameter int CW   = 16,
  parameter int FRAC = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  muestra_in,
  input  logic          muestra_valid,
  input  logic          coef_we,
  input  logic [2:0]    coef_addr,
  input  logic [CW-1:0] coef_data,
  input  logic          paso,
  input  logic [2:0]    Sel_cons,
  input  logic          Sel_ac,
  input  logic          listo,
  output logic [W-1:0]  salida,
  output logic          salida_valid,
  output logic          busy,
  output logic          overrun
);

  localparam int PW = W + CW;
  localparam int AW = W + CW + 3;

  logic signed [CW-1:0] coef_q [5];
  logic signed [W-1:0]  x0_q, x1_q, x2_q, y1_q, y2_q;
  logic signed [W-1:0]  x0_d, x1_d, x2_d, y1_d, y2_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [W-1:0]         sal_q, sal_d;
  logic                 val_q, val_d;
  logic                 busy_q, busy_d;
  logic                 ovr_q, ovr_d;

  logic                 step, fin, take;
  logic signed [CW-1:0] c_sel;
  logic signed [W-1:0]  op_sel;
  logic [PW-1:0]        prod;
  logic signed [AW-1:0] prod_x, acc_nx, shr;
  logic signed [W-1:0]  y;

  always_comb begin
    step = paso & busy_q;
    fin  = step & listo;
    take = muestra_valid & (~busy_q | fin);

    c_sel  = '0;
    op_sel = '0;
    case (Sel_cons)
      3'd0: begin c_sel = coef_q[0]; op_sel = x0_q; end
      3'd1: begin c_sel = coef_q[1]; op_sel = x1_q; end
      3'd2: begin c_sel = coef_q[2]; op_sel = x2_q; end
      3'd3: begin c_sel = coef_q[3]; op_sel = y1_q; end
      3'd4: begin c_sel = coef_q[4]; op_sel = y2_q; end
      default: begin c_sel = '0; op_sel = '0; end
    endcase

    // Both factors sign-extended to PW bits: the low PW bits of the
    // product are then the exact signed product.
    prod   = {{W{c_sel[CW-1]}}, c_sel} * {{CW{op_sel[W-1]}}, op_sel};
    prod_x = {{(AW-PW){prod[PW-1]}}, prod};
    acc_nx = Sel_ac ? acc_q + prod_x : prod_x;
    shr    = acc_nx >>> FRAC;

    // In range only if all bits above the output sign bit match it.
    if (shr[AW-1:W-1] == {(AW-W+1){shr[AW-1]}})
      y = shr[W-1:0];
    else if (shr[AW-1])
      y = {1'b1, {(W-1){1'b0}}};
    else
      y = {1'b0, {(W-1){1'b1}}};

    x0_d   = x0_q;
    x1_d   = x1_q;
    x2_d   = x2_q;
    y1_d   = y1_q;
    y2_d   = y2_q;
    acc_d  = acc_q;
    sal_d  = sal_q;
    val_d  = 1'b0;
    busy_d = busy_q;
    ovr_d  = ovr_q;

    if (step)
      acc_d = acc_nx;
    if (fin) begin
      sal_d  = y;
      val_d  = 1'b1;
      x2_d   = x1_q;
      x1_d   = x0_q;
      y2_d   = y1_q;
      y1_d   = y;
      busy_d = 1'b0;
    end
    if (take) begin
      x0_d   = muestra_in;
      busy_d = 1'b1;
    end else if (muestra_valid) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 5; i++)
        coef_q[i] <= '0;
      x0_q   <= '0;
      x1_q   <= '0;
      x2_q   <= '0;
      y1_q   <= '0;
      y2_q   <= '0;
      acc_q  <= '0;
      sal_q  <= '0;
      val_q  <= 1'b0;
      busy_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      for (int i = 0; i < 5; i++)
        if (coef_we && coef_addr == 3'(i))
          coef_q[i] <= coef_data;
      x0_q   <= x0_d;
      x1_q   <= x1_d;
      x2_q   <= x2_d;
      y1_q   <= y1_d;
      y2_q   <= y2_d;
      acc_q  <= acc_d;
      sal_q  <= sal_d;
      val_q  <= val_d;
      busy_q <= busy_d;
      ovr_q  <= ovr_d;
    end
  end

  assign salida       = sal_q;
  assign salida_valid = val_q;
  assign busy         = busy_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_datapath_filtro.sv
// Self-checking bench for datapath_filtro against a direct-form equation model.
// Drives samples, coefficient writes and MAC step sequences.
module tb_datapath_filtro;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] muestra_in;
  logic        muestra_valid;
  logic        coef_we;
  logic [2:0]  coef_addr;
  logic [15:0] coef_data;
  logic        paso;
  logic [2:0]  Sel_cons;
  logic        Sel_ac;
  logic        listo;
  logic [15:0] salida;
  logic        salida_valid;
  logic        busy;
  logic        overrun;

  int total = 0;
  int bad   = 0;

  int mc[5];
  int mx0, mx1, mx2, my1, my2;

  datapath_filtro #(.W(16), .CW(16), .FRAC(14)) dut (
    .clk          (clk),
    .reset        (reset),
    .muestra_in   (muestra_in),
    .muestra_valid(muestra_valid),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data),
    .paso         (paso),
    .Sel_cons     (Sel_cons),
    .Sel_ac       (Sel_ac),
    .listo        (listo),
    .salida       (salida),
    .salida_valid (salida_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int i = 0; i < 5; i++) mc[i] = 0;
    mx0 = 0; mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
  endfunction

  function automatic int model_fin();
    longint a;
    int     yv;
    a = longint'(mc[0]) * mx0 + longint'(mc[1]) * mx1
      + longint'(mc[2]) * mx2 + longint'(mc[3]) * my1
      + longint'(mc[4]) * my2;
    a = a >>> 14;
    if (a > 32767)       yv = 32767;
    else if (a < -32768) yv = -32768;
    else                 yv = int'(a);
    mx2 = mx1; mx1 = mx0; my2 = my1; my1 = yv;
    return yv;
  endfunction

  // ---------------- drivers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    muestra_in = '0; muestra_valid = 0; coef_we = 0;
    coef_addr = '0; coef_data = '0; paso = 0;
    Sel_cons = '0; Sel_ac = 0; listo = 0;
  endtask

  task automatic do_reset(input int n);
    reset = 1;
    repeat (n) cyc();
    reset = 0;
    model_reset();
  endtask

  task automatic wr_coef(input int a, input int d);
    coef_we = 1; coef_addr = a[2:0]; coef_data = d[15:0];
    cyc();
    coef_we = 0;
    if (a <= 4) mc[a] = d;
  endtask

  task automatic send(input int x);
    muestra_in = x[15:0]; muestra_valid = 1;
    cyc();
    muestra_valid = 0;
  endtask

  task automatic mac(input int sel, input bit ac, input bit lst);
    paso = 1; Sel_cons = sel[2:0]; Sel_ac = ac; listo = lst;
    cyc();
    paso = 0; listo = 0;
  endtask

  // Capture x (optional) then run a MAC sequence; returns outputs
  // sampled one cycle after the listo edge.
  task automatic feed(input int x, input bit do_take, input bit shuf,
                      output logic [15:0] s, output logic v,
                      output logic b);
    int ord[6];
    int n, t, j;
    if (do_take) send(x);
    for (int i = 0; i < 5; i++) ord[i] = i;
    ord[5] = 5 + $urandom_range(0, 2);
    n = shuf ? 6 : 5;
    if (shuf)
      for (int i = n - 1; i > 0; i--) begin
        j = $urandom_range(0, i);
        t = ord[i]; ord[i] = ord[j]; ord[j] = t;
      end
    for (int i = 0; i < n; i++) begin
      if (shuf) repeat ($urandom_range(0, 2)) cyc();
      mac(ord[i], i != 0, i == n - 1);
    end
    s = salida; v = salida_valid; b = busy;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [15:0] s; logic v, b;
    int e;
    do_reset(2);
    total++; if (salida !== 16'd0) begin bad++; $display("FAIL reset_salida got=%0h exp=0", salida); end
    total++; if (salida_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", salida_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    wr_coef(0, 16384);
    wr_coef(1, 16384);
    send(700);
    mac(0, 0, 0);
    mac(1, 1, 0);
    mac(2, 1, 0);
    paso = 1; Sel_cons = 3; Sel_ac = 1; listo = 1; reset = 1;
    cyc();
    paso = 0; listo = 0;
    cyc();
    reset = 0;
    model_reset();
    total++; if (salida_valid !== 1'b0 || busy !== 1'b0 || salida !== 16'd0)
      begin bad++; $display("FAIL midreset got v=%b b=%b s=%0d exp v=0 b=0 s=0", salida_valid, busy, salida); end
    wr_coef(0, 16384);
    wr_coef(1, 16384);
    feed(500, 1, 0, s, v, b);
    mx0 = 500; e = model_fin();
    total++; if ($signed(s) !== e || v !== 1'b1)
      begin bad++; $display("FAIL reset_history got=%0d v=%b exp=%0d v=1", $signed(s), v, e); end
  endtask

  task automatic test_passthrough();
    logic [15:0] s; logic v, b;
    do_reset(1);
    wr_coef(0, 16384);
    feed(1000, 1, 0, s, v, b);
    total++; if (s !== 16'd1000 || v !== 1'b1 || b !== 1'b0)
      begin bad++; $display("FAIL pass got s=%0d v=%b b=%b exp s=1000 v=1 b=0", $signed(s), v, b); end
    cyc();
    total++; if (salida_valid !== 1'b0 || salida !== 16'd1000)
      begin bad++; $display("FAIL pass_hold got v=%b s=%0d exp v=0 s=1000", salida_valid, $signed(salida)); end
  endtask

  task automatic test_delay();
    logic [15:0] s; logic v, b;
    int xs[3] = '{100, 200, 300};
    int e;
    do_reset(1);
    wr_coef(2, 16384);
    for (int i = 0; i < 3; i++) begin
      feed(xs[i], 1, 0, s, v, b);
      mx0 = xs[i]; e = model_fin();
      total++; if ($signed(s) !== e || v !== 1'b1)
        begin bad++; $display("FAIL delay%0d got=%0d exp=%0d", i, $signed(s), e); end
    end
  endtask

  task automatic test_feedback();
    logic [15:0] s; logic v, b;
    int exp_y[4] = '{1000, 500, 250, 125};
    do_reset(1);
    wr_coef(0, 16384);
    wr_coef(3, 8192);
    for (int i = 0; i < 4; i++) begin
      feed(i == 0 ? 1000 : 0, 1, 0, s, v, b);
      total++; if ($signed(s) !== exp_y[i])
        begin bad++; $display("FAIL feedback%0d got=%0d exp=%0d", i, $signed(s), exp_y[i]); end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] s; logic v, b;
    do_reset(1);
    wr_coef(0, 32767);
    feed(30000, 1, 0, s, v, b);
    total++; if ($signed(s) !== 32767)
      begin bad++; $display("FAIL sat_pos got=%0d exp=32767", $signed(s)); end
    feed(-30000, 1, 0, s, v, b);
    total++; if ($signed(s) !== -32768)
      begin bad++; $display("FAIL sat_neg got=%0d exp=-32768", $signed(s)); end
    wr_coef(0, 0);
    wr_coef(3, 16384);
    feed(0, 1, 0, s, v, b);
    total++; if ($signed(s) !== -32768)
      begin bad++; $display("FAIL sat_fedback got=%0d exp=-32768", $signed(s)); end
  endtask

  task automatic test_overrun();
    logic [15:0] s; logic v, b;
    do_reset(1);
    wr_coef(0, 16384);
    send(1111);
    send(2222);
    total++; if (overrun !== 1'b1)
      begin bad++; $display("FAIL overrun_set got=%b exp=1", overrun); end
    feed(0, 0, 0, s, v, b);
    total++; if (s !== 16'd1111 || overrun !== 1'b1)
      begin bad++; $display("FAIL overrun_x0 got s=%0d ovr=%b exp s=1111 ovr=1", $signed(s), overrun); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] s; logic v, b;
    int e;
    do_reset(1);
    wr_coef(0, 16384);
    wr_coef(1, 16384);
    send(100);
    mx0 = 100;
    mac(0, 0, 0);
    mac(1, 1, 0);
    mac(2, 1, 0);
    mac(3, 1, 0);
    muestra_in = 16'd200; muestra_valid = 1;
    mac(4, 1, 1);
    muestra_valid = 0;
    e = model_fin();
    mx0 = 200;
    total++; if ($signed(salida) !== e || salida_valid !== 1'b1 || busy !== 1'b1 || overrun !== 1'b0)
      begin bad++; $display("FAIL simul got s=%0d v=%b b=%b o=%b exp s=%0d v=1 b=1 o=0",
        $signed(salida), salida_valid, busy, overrun, e); end
    feed(0, 0, 0, s, v, b);
    e = model_fin();
    total++; if ($signed(s) !== e || v !== 1'b1)
      begin bad++; $display("FAIL simul_next got=%0d exp=%0d", $signed(s), e); end
  endtask

  task automatic test_misc();
    logic [15:0] held;
    do_reset(1);
    wr_coef(0, 16384);
    send(42);
    paso = 0; listo = 1;
    cyc();
    listo = 0;
    total++; if (salida_valid !== 1'b0 || busy !== 1'b1)
      begin bad++; $display("FAIL listo_nopaso got v=%b b=%b exp v=0 b=1", salida_valid, busy); end
    wr_coef(7, 999);
    mac(0, 0, 0);
    mac(1, 1, 0);
    mac(7, 1, 1);
    held = salida;
    total++; if (held !== 16'd42 || salida_valid !== 1'b1)
      begin bad++; $display("FAIL sel_oob got=%0d exp=42", $signed(held)); end
    mac(0, 1, 1);
    total++; if (salida_valid !== 1'b0 || salida !== held)
      begin bad++; $display("FAIL paso_idle got v=%b s=%0d exp v=0 s=%0d", salida_valid, $signed(salida), $signed(held)); end
  endtask

  task automatic test_random();
    logic [15:0] s; logic v, b;
    int e, x;
    do_reset(1);
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 3) == 0 || k == 0)
        for (int i = 0; i < 5; i++)
          wr_coef(i, $urandom_range(0, 1) ? int'($urandom_range(0, 32767)) - 16384
                                          : int'($urandom_range(0, 65535)) - 32768);
      x = int'($urandom_range(0, 65535)) - 32768;
      feed(x, 1, 1, s, v, b);
      mx0 = x; e = model_fin();
      total++; if ($signed(s) !== e || v !== 1'b1 || b !== 1'b0)
        begin bad++; $display("FAIL rand%0d got s=%0d v=%b b=%b exp s=%0d v=1 b=0", k, $signed(s), v, b, e); end
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    model_reset();
    test_reset();
    test_passthrough();
    test_delay();
    test_feedback();
    test_saturation();
    test_overrun();
    test_back_to_back();
    test_misc();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
